plic_hart_agent: RTL



---
 rtl/plic_pkg.sv | 21 ++
 rtl/plic_hart_agent.sv | 101 ++++++++++
 2 files changed

// File: rtl/plic_pkg.sv
// Shared PLIC definitions: hart-agent state encoding, counter widths and the
// ID-width helper used by the core and the per-target agents.
package plic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CLAIM,
    ACTIVE,
    COMPLETE,
    HOLD
  } agent_state_t;

  localparam int unsigned GUARD_W = 4;

  // ID 0 is reserved for "no interrupt", hence SOURCES+1 codes.
  function automatic int unsigned sources_bits(input int unsigned sources);
    return $clog2(sources + 1);
  endfunction

endpackage

// File: rtl/plic_hart_agent.sv
// Per-target claim/complete sequencer between the PLIC core and a hart:
// one outstanding claim, post-complete guard window, optional handler watchdog.
module plic_hart_agent
  import plic_pkg::*;
#(
  parameter int unsigned SOURCES      = 8,
  parameter int unsigned SOURCES_BITS = sources_bits(SOURCES),
  parameter int unsigned GUARD        = 2,
  parameter int unsigned TIMEOUT      = 0
) (
  input  logic                    rst_n,
  input  logic                    clk,
  input  logic                    ireq_i,
  input  logic [SOURCES_BITS-1:0] id_i,
  output logic                    claim_o,
  output logic                    complete_o,
  output logic                    irq_o,
  input  logic                    ack_i,
  output logic [SOURCES_BITS-1:0] id_o,
  output logic                    id_vld_o,
  input  logic                    done_i,
  output logic                    busy_o,
  output logic                    spurious_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);

  localparam int unsigned       WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [GUARD_W-1:0] GUARD_LD = GUARD_W'(GUARD);

  agent_state_t        state, state_nxt;
  logic [GUARD_W-1:0]  guard_q;
  logic [WD_W-1:0]     wd_q;
  logic                wd_exp;
  logic                spur_claim;

  assign wd_exp     = (TIMEOUT != 0) && (wd_q == WD_MAX);
  assign spur_claim = (state == CLAIM) && (id_i == '0);

  assign irq_o      = (state == REQ);
  assign claim_o    = (state == CLAIM);
  assign complete_o = (state == COMPLETE);
  assign busy_o     = (state == ACTIVE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (ireq_i && (guard_q == '0)) state_nxt = REQ;
      REQ: begin
        if (ack_i)        state_nxt = CLAIM;
        else if (!ireq_i) state_nxt = IDLE;
      end
      CLAIM:    state_nxt = (id_i != '0) ? ACTIVE : HOLD;
      ACTIVE:   if (done_i || wd_exp) state_nxt = COMPLETE;
      COMPLETE: state_nxt = HOLD;
      // The last guard cycle evaluates the IDLE entry condition itself so the
      // next irq_o can rise GUARD+1 cycles after complete_o.
      HOLD:     if (guard_q <= GUARD_W'(1)) state_nxt = ireq_i ? REQ : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      guard_q    <= '0;
      wd_q       <= '0;
      id_o       <= '0;
      id_vld_o   <= 1'b0;
      spurious_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_nxt;
      id_vld_o   <= 1'b0;
      spurious_o <= 1'b0;

      if (state == CLAIM) begin
        id_o       <= id_i;
        id_vld_o   <= (id_i != '0);
        spurious_o <= (id_i == '0);
      end

      if ((state == COMPLETE) || spur_claim)
        guard_q <= GUARD_LD;
      else if ((state == HOLD) && (guard_q != '0))
        guard_q <= guard_q - 1'b1;

      if (state != ACTIVE)
        wd_q <= '0;
      else if (wd_q != WD_MAX)
        wd_q <= wd_q + 1'b1;

      if (err_clr_i)
        err_o <= 1'b0;
      else if ((state == ACTIVE) && wd_exp && !done_i)
        err_o <= 1'b1;
    end
  end

endmodule
